// File: rtl/div_seq.sv
// ============================================================================
// Module   : div_seq
// Purpose  : multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (HI/LO)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      quo_q, quo_d;
  logic [WIDTH-1:0]      dvs_q, dvs_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic [2*WIDTH-1:0]    result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  dbz_q, dbz_d;

  logic [WIDTH-1:0]      w_abs1, w_abs2;
  logic                  w_sign1, w_sign2;
  logic [WIDTH:0]        w_rem_sh;
  logic [WIDTH:0]        w_diff;
  logic [WIDTH-1:0]      w_step_rem, w_step_quo;
  logic                  w_div_zero;
  logic                  w_last_step;

  // Magnitudes; -2^(W-1) negates to itself and is then read as unsigned.
  assign w_sign1    = signed_i & opdata1_i[WIDTH-1];
  assign w_sign2    = signed_i & opdata2_i[WIDTH-1];
  assign w_abs1     = w_sign1 ? -opdata1_i : opdata1_i;
  assign w_abs2     = w_sign2 ? -opdata2_i : opdata2_i;
  assign w_div_zero = (opdata2_i == '0);

  // Partial remainder is always < divisor, so the shifted value fits W+1 bits.
  assign w_rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, dvs_q};
  assign w_step_rem = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_step_quo = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (w_div_zero) begin
            result_d = '0;
            dbz_d    = 1'b1;
            ready_d  = 1'b1;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = w_abs1;
            dvs_d   = w_abs2;
            negq_d  = w_sign1 ^ w_sign2;
            negr_d  = w_sign1;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = w_step_rem;
          quo_d = w_step_quo;
          cnt_d = cnt_q + 1'b1;
          if (w_last_step) begin
            result_d = {(negr_q ? -w_step_rem : w_step_rem),
                        (negq_q ? -w_step_quo : w_step_quo)};
            ready_d  = 1'b1;
            dbz_d    = 1'b0;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!start_i || annul_i) begin
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      dbz_q    <= dbz_d;
    end
  end

  // Stall is dropped in DONE so the pipeline advances on the ready cycle.
  assign busy_o = ((state_q == S_RUN) && !annul_i) ||
                  ((state_q == S_IDLE) && start_i && !annul_i && !w_div_zero);

  assign result_o      = result_q;
  assign ready_o       = ready_q;
  assign div_by_zero_o = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module   : tb_div_seq
// Purpose  : self-checking bench for div_seq (vector table, random ops, corners)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic           annul_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;
  logic           div_by_zero_o;

  int checks   = 0;
  int failures = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .annul_i       (annul_i),
    .opdata1_i     (opdata1_i),
    .opdata2_i     (opdata2_i),
    .result_o      (result_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .div_by_zero_o (div_by_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating division gives
  // remainder sign = dividend sign, and the overflow case wraps when truncated.
  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    if (b == 0) begin
      q = '0; r = '0; dbz = 1'b1;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      sq = sa / sb;
      sr = sa % sb;
      q = sq[W-1:0]; r = sr[W-1:0]; dbz = 1'b0;
    end else begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      q = W'(ua / ub); r = W'(ua % ub); dbz = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edbz);
    int       lat;
    logic     busy_err;
    logic     hold_err;
    logic [63:0] exp_res;
    exp_res = edbz ? 64'd0 : {er, eq};
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    check({name, "_busy_req"}, 64'(busy_o), 64'(b != 0));
    lat = 0;
    busy_err = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~s;
      end
      if (ready_o) break;
      if (busy_o !== 1'b1) busy_err = 1'b1;
    end
    check({name, "_latency"}, 64'(lat), edbz ? 64'd1 : 64'd33);
    check({name, "_busy_run"}, 64'(busy_err), 64'd0);
    check({name, "_result"}, result_o, exp_res);
    check({name, "_dbz"}, 64'(div_by_zero_o), 64'(edbz));
    check({name, "_busy_done"}, 64'(busy_o), 64'd0);
    hold_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== exp_res || div_by_zero_o !== edbz) hold_err = 1'b1;
    end
    check({name, "_hold"}, 64'(hold_err), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, "_ready_clr"}, {62'd0, ready_o, div_by_zero_o}, 64'd0);
    check({name, "_result_keep"}, result_o, exp_res);
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         rs, md;
    logic         rose;

    vecs[0] = '{1'b0, 32'd7,         32'd2,         32'd3,         32'd1,         1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[5] = '{1'b0, 32'd5,         32'd0,         32'd0,         32'd0,         1'b1};
    vecs[6] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
    vecs[8] = '{1'b1, 32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0};
    vecs[9] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #1;
    check("reset_outputs", {result_o[61:0], ready_o, div_by_zero_o}, 64'd0);
    check("reset_result_hi", 64'(result_o[63:62]), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_busy", 64'(busy_o), 64'd0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].dbz);

    // Annul in the middle of the run: nothing must be reported.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    check("annul_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o || busy_o) rose = 1'b1;
    end
    check("annul_no_ready", 64'(rose), 64'd0);
    run_op("after_annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Asynchronous reset between edges while running.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'hFFFF0000; opdata2_i = 32'd9;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_mid_run", {result_o[61:0], ready_o, div_by_zero_o}, 64'd0);
    check("rst_mid_run_hi", 64'(result_o[63:62]), 64'd0);
    check("rst_mid_run_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);

    for (int n = 0; n < 30; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = $urandom_range(0, 9);
        1: rb = -$urandom_range(1, 9);
        2: ra = 32'h80000000;
        default: ;
      endcase
      model(rs, ra, rb, mq, mr, md);
      run_op($sformatf("rand%0d", n), rs, ra, rb, mq, mr, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
